// File: rtl/cad_pkg.sv
// Shared types and constants for the CAD engine result path.
package cad_pkg;

    localparam int CAD_RESULT_W = 20;

    typedef logic signed [CAD_RESULT_W-1:0] cad_result_t;

    typedef enum logic {
        SER_IDLE  = 1'b0,
        SER_SHIFT = 1'b1
    } ser_state_e;

endpackage

// File: rtl/cad_result_serializer_if.sv
// Push port and serial output bundle of the CAD result serialiser.
interface cad_result_serializer_if #(
    parameter int RESULT_W = 20,
    parameter int DEPTH    = 4
);
    localparam int LVL_W = $clog2(DEPTH + 1);

    logic                       in_valid;
    logic signed [RESULT_W-1:0] in_data;
    logic                       in_msb_first;
    logic                       in_ready;
    logic                       out_valid;
    logic                       out_value;
    logic                       out_last;
    logic [LVL_W-1:0]           fifo_level;

    modport master (
        output in_valid, in_data, in_msb_first,
        input  in_ready, out_valid, out_value, out_last, fifo_level
    );

    modport slave (
        input  in_valid, in_data, in_msb_first,
        output in_ready, out_valid, out_value, out_last, fifo_level
    );

endinterface

// File: rtl/cad_sync_fifo.sv
// Synchronous FIFO with wrapping power-of-two pointers and a separate level counter.
module cad_sync_fifo #(
    parameter int WIDTH = 21,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push_i,
    input  logic                         pop_i,
    input  logic [WIDTH-1:0]             din_i,
    output logic [WIDTH-1:0]             dout_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH+1)-1:0]   level_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             do_push, do_pop;

    assign full_o  = (level_q == LVL_W'(DEPTH));
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign dout_o  = mem_q[rd_ptr_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        unique case ({do_push, do_pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    // Storage is not reset; only pointers and level define validity.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

endmodule

// File: rtl/cad_result_serializer.sv
// Bit-serial output stage: FIFO-buffered results streamed one bit per cycle, gapless.
// Define CAD_SER_PARITY_EN to append an even-parity bit to every result frame.
//
//  state     | meaning
//  SER_IDLE  | nothing shifting; pops the FIFO head as soon as it is non-empty
//  SER_SHIFT | emitting frame bit cnt; reloads from the FIFO on the final bit
module cad_result_serializer
    import cad_pkg::*;
#(
    parameter int RESULT_W = CAD_RESULT_W,
    parameter int DEPTH    = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    cad_result_serializer_if.slave   bus_if
);
    localparam int LVL_W = $clog2(DEPTH + 1);
`ifdef CAD_SER_PARITY_EN
    localparam int FRAME_W = RESULT_W + 1;
`else
    localparam int FRAME_W = RESULT_W;
`endif
    localparam int                 CNT_W    = $clog2(FRAME_W);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(FRAME_W - 1);
    localparam logic [CNT_W-1:0]   IDX_TOP  = CNT_W'(RESULT_W - 1);

    ser_state_e          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [RESULT_W-1:0] data_q, data_d;
    logic                msb_q, msb_d;
    logic                out_valid_q, out_valid_d;
    logic                out_value_q, out_value_d;
    logic                out_last_q, out_last_d;
    logic [CNT_W-1:0]    bit_idx;

    logic                fifo_pop;
    logic                fifo_full;
    logic                fifo_empty;
    logic [RESULT_W:0]   fifo_dout;
    logic [LVL_W-1:0]    fifo_level;

    cad_sync_fifo #(
        .WIDTH (RESULT_W + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (bus_if.in_valid),
        .pop_i   (fifo_pop),
        .din_i   ({bus_if.in_msb_first, bus_if.in_data}),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level)
    );

    assign bus_if.in_ready   = !fifo_full;
    assign bus_if.fifo_level = fifo_level;
    assign bus_if.out_valid  = out_valid_q;
    assign bus_if.out_value  = out_value_q;
    assign bus_if.out_last   = out_last_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        data_d   = data_q;
        msb_d    = msb_q;
        fifo_pop = 1'b0;
        unique case (state_q)
            SER_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop        = 1'b1;
                    {msb_d, data_d} = fifo_dout;
                    cnt_d           = '0;
                    state_d         = SER_SHIFT;
                end
            end
            SER_SHIFT: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (!fifo_empty) begin
                        fifo_pop        = 1'b1;
                        {msb_d, data_d} = fifo_dout;
                    end else begin
                        state_d = SER_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = SER_IDLE;
        endcase

        // Output flops are loaded with the bit that the next state will present.
        bit_idx     = msb_d ? (IDX_TOP - cnt_d) : cnt_d;
        out_valid_d = (state_d == SER_SHIFT);
        out_last_d  = out_valid_d && (cnt_d == CNT_LAST);
        out_value_d = out_valid_d && data_d[bit_idx];
`ifdef CAD_SER_PARITY_EN
        if (cnt_d == CNT_LAST) out_value_d = out_valid_d && (^data_d);
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= SER_IDLE;
            cnt_q       <= '0;
            data_q      <= '0;
            msb_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_value_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            data_q      <= data_d;
            msb_q       <= msb_d;
            out_valid_q <= out_valid_d;
            out_value_q <= out_value_d;
            out_last_q  <= out_last_d;
        end
    end

endmodule

// File: tb/tb_cad_result_serializer.sv
// Self-checking bench for cad_result_serializer: per-cycle schedule model plus directed literals.
module tb_cad_result_serializer;
    import cad_pkg::*;

    localparam int RW = CAD_RESULT_W;
    localparam int DP = 4;
`ifdef CAD_SER_PARITY_EN
    localparam int F = RW + 1;
`else
    localparam int F = RW;
`endif

    logic   clk   = 1'b0;
    logic   rst_n = 1'b1;
    int     total = 0;
    int     bad   = 0;
    longint cyc   = 0;

    // Expected serial stream keyed by cycle number, plus push/start edges per result.
    bit     exp_bit  [longint];
    bit     exp_last [longint];
    longint q_push[$];
    longint q_start[$];
    longint next_free = 0;

    cad_result_serializer_if #(.RESULT_W(RW), .DEPTH(DP)) bus ();

    cad_result_serializer #(.RESULT_W(RW), .DEPTH(DP)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_if (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Result pushed at edge e starts at edge max(e+1, end of previous frame).
    function automatic void model_push(input logic [RW-1:0] d, input bit m, input longint e);
        longint s;
        bit     b;
        s = (e + 1 > next_free) ? e + 1 : next_free;
        for (int k = 0; k < F; k++) begin
            if (k < RW) b = m ? d[RW-1-k] : d[k];
            else        b = ^d;
            exp_bit[s+k]  = b;
            exp_last[s+k] = (k == F - 1);
        end
        next_free = s + F;
        q_push.push_back(e);
        q_start.push_back(s);
    endfunction

    function automatic int model_level(input longint c);
        int n = 0;
        foreach (q_push[i]) if (q_push[i] <= c && q_start[i] > c) n++;
        return n;
    endfunction

    function automatic void model_clear();
        exp_bit.delete();
        exp_last.delete();
        q_push.delete();
        q_start.delete();
        next_free = 0;
    endfunction

    bit ev;
    int lvl;
    always @(negedge clk) begin
        if (rst_n) begin
            ev = exp_bit.exists(cyc);
            chk("out_valid", bus.out_valid, ev);
            if (ev) begin
                chk("out_value", bus.out_value, exp_bit[cyc]);
                chk("out_last", bus.out_last, exp_last[cyc]);
                exp_bit.delete(cyc);
                exp_last.delete(cyc);
            end
            lvl = model_level(cyc);
            chk("fifo_level", bus.fifo_level, lvl);
            chk("in_ready", bus.in_ready, lvl != DP);
            while (q_start.size() > 0 && q_start[0] <= cyc) begin
                void'(q_start.pop_front());
                void'(q_push.pop_front());
            end
        end
    end

    // Called at a negedge; never raises in_valid unless in_ready is high.
    task automatic step(input bit v, input logic [RW-1:0] d, input bit m, output bit acc);
        acc              = v && bus.in_ready;
        bus.in_valid     = acc;
        bus.in_data      = d;
        bus.in_msb_first = m;
        if (acc) model_push(d, m, cyc + 1);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        bit a;
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, a);
    endtask

    task automatic do_reset();
        bus.in_valid = 1'b0;
        rst_n        = 1'b0;
        model_clear();
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        bit          acc;
        int          w;
        logic [RW-1:0] d;
        cad_result_t neg_one;

        bus.in_valid     = 1'b0;
        bus.in_data      = '0;
        bus.in_msb_first = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_value", bus.out_value, 0);
        chk("rst_out_last", bus.out_last, 0);
        chk("rst_level", bus.fifo_level, 0);
        chk("rst_in_ready", bus.in_ready, 1);
        do_reset();

        // Single LSB-first 20'h80001: two-cycle latency, 1, eighteen 0s, 1.
        step(1'b1, 20'h80001, 1'b0, acc);
        chk("t1_acc", acc, 1);
        chk("t1_lat_valid", bus.out_valid, 0);
        for (int k = 0; k < F; k++) begin
            idle(1);
            chk("t1_valid", bus.out_valid, 1);
            chk("t1_value", bus.out_value, (k == 0 || k == 19) ? 1 : 0);
            chk("t1_last", bus.out_last, (k == F - 1) ? 1 : 0);
        end
        idle(1);
        chk("t1_valid_fall", bus.out_valid, 0);
        idle(3);

        // MSB-first -1 then LSB-first 0, back to back with no bubble.
        neg_one = -20'sd1;
        step(1'b1, neg_one, 1'b1, acc);
        chk("t2_acc_a", acc, 1);
        step(1'b1, 20'h00000, 1'b0, acc);
        chk("t2_acc_b", acc, 1);
        for (int k = 0; k < 2 * F; k++) begin
            chk("t2_valid", bus.out_valid, 1);
            chk("t2_value", bus.out_value, (k < RW) ? 1 : 0);
            chk("t2_last", bus.out_last, (k == F - 1 || k == 2 * F - 1) ? 1 : 0);
            idle(1);
        end
        chk("t2_valid_fall", bus.out_valid, 0);
        idle(3);

`ifdef CAD_SER_PARITY_EN
        // Three ones give parity 1 on the 21st bit.
        step(1'b1, 20'h00007, 1'b0, acc);
        idle(1);
        for (int k = 0; k < F; k++) begin
            chk("tp_valid", bus.out_valid, 1);
            chk("tp_value", bus.out_value, (k < 3 || k == RW) ? 1 : 0);
            chk("tp_last", bus.out_last, (k == F - 1) ? 1 : 0);
            idle(1);
        end
        chk("tp_valid_fall", bus.out_valid, 0);
        idle(3);
`endif

        // Fill to DEPTH while the first result shifts.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            d = RW'($urandom());
            step(1'b1, d, 1'($urandom_range(0, 1)), acc);
            chk("t3_acc", acc, 1);
        end
        chk("t3_full_level", bus.fifo_level, 4);
        chk("t3_full_ready", bus.in_ready, 0);
        w = 0;
        while (bus.fifo_level == 4 && w < 2 * F) begin
            idle(1);
            w++;
        end
        chk("t3_pop_level", bus.fifo_level, 3);
        chk("t3_pop_ready", bus.in_ready, 1);
        idle(5 * F + 5);

        // Reset at bit 7 with two entries queued.
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b1, RW'($urandom()), 1'($urandom_range(0, 1)), acc);
        w = 0;
        while (!bus.out_valid && w < 10) begin
            idle(1);
            w++;
        end
        chk("t4_started", bus.out_valid, 1);
        idle(7);
        chk("t4_pre_level", bus.fifo_level, 2);
        #2 rst_n = 1'b0;
        model_clear();
        #1;
        chk("t4_rst_valid", bus.out_valid, 0);
        chk("t4_rst_value", bus.out_value, 0);
        chk("t4_rst_last", bus.out_last, 0);
        chk("t4_rst_level", bus.fifo_level, 0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("t4_post_level", bus.fifo_level, 0);
        idle(2 * F);
        step(1'b1, RW'($urandom()), 1'b1, acc);
        idle(F + 4);

        // Push lands on the same edge as the last-bit pop, level 2.
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b1, RW'($urandom()), 1'($urandom_range(0, 1)), acc);
        w = 0;
        while (!bus.out_last && w < F + 5) begin
            idle(1);
            w++;
        end
        chk("t5_at_last", bus.out_last, 1);
        chk("t5_pre_level", bus.fifo_level, 2);
        step(1'b1, RW'($urandom()), 1'($urandom_range(0, 1)), acc);
        chk("t5_acc", acc, 1);
        chk("t5_level", bus.fifo_level, 2);
        chk("t5_next_valid", bus.out_valid, 1);
        chk("t5_next_last", bus.out_last, 0);
        idle(4 * F + 4);

        // Randomised traffic against the schedule model.
        do_reset();
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 2) != 0, RW'($urandom()), 1'($urandom_range(0, 1)), acc);
        idle(6 * F);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cad_result_serializer.md
Name: cad_result_serializer

Overview:
- Parametrised bit-serial output stage for the convolution/deconvolution (CAD) engine.
- Takes signed parallel results from the datapath through a valid/ready push port and buffers them in a DEPTH-entry FIFO.
- Streams each result on a single out_valid/out_value pin pair, one bit per cycle, with no gaps while data is queued.
- Replaces the fixed-width, fixed-order serialiser with a configurable result width, FIFO depth and per-result bit order.

Parameters:
- RESULT_W, 20, result width in bits; legal range 2..32.
- DEPTH, 4, FIFO entries; must be a power of two, at least 2.
- LVL_W, $clog2(DEPTH+1), localparam; width of fifo_level.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  push request for in_data.
- in_data  input  RESULT_W  signed result, two's complement.
- in_msb_first  input  1  bit order for this result, sampled with the push: 1 = MSB first, 0 = LSB first.
- in_ready  output  1  FIFO can accept a push.
- out_valid  output  1  out_value carries a result bit.
- out_value  output  1  serial result bit.
- out_last  output  1  high on the final bit of each result.
- fifo_level  output  LVL_W  number of queued results, not counting the one currently shifting.

Behaviour:
- Reset (async assert, sync deassert edge is the bench's responsibility):
  - out_valid, out_value, out_last = 0.
  - FIFO empty; fifo_level = 0; in_ready = 1.
  - FSM = IDLE; bit counter = 0.
- Reset mid-stream aborts the current result immediately and discards all queued entries. No partial bits follow reset release.
- Push: accepted on a rising edge where in_valid && in_ready.
  - The entry stored is {in_msb_first, in_data}.
  - in_ready = (fifo_level != DEPTH). It is registered-state derived and has no combinational path from out-side activity.
  - in_valid while in_ready = 0 is ignored and the data is dropped. Assertion: this must never happen in the bench.
- FSM IDLE:
  - If the FIFO is non-empty at an edge, pop the head into the shift register, load the bit counter = 0, go to SHIFT.
  - out_valid is 0 while in IDLE.
- FSM SHIFT:
  - out_valid = 1.
  - out_value = the current bit: bit[cnt] if LSB-first, bit[RESULT_W-1-cnt] if MSB-first.
  - cnt increments each edge.
  - out_last = 1 when cnt == RESULT_W-1 (or the parity slot, see Optional Feature).
  - On the last-bit edge: if the FIFO is non-empty, pop and reload with zero bubble; otherwise go to IDLE.
- Latency: a push accepted on edge E0 into an empty, idle block gives the first bit on the cycle after edge E1, i.e. 2 cycles.
- Simultaneous push and pop on the same edge: both happen; fifo_level is unchanged.
- Push into a full FIFO on the same edge as a pop is not allowed. in_ready stays 0 for that cycle and there is no bypass.
- FIFO read and write pointers are log2(DEPTH) bits and wrap naturally. The level counter is a separate register.
- Outputs are driven directly from flops (out_valid, out_value, out_last) with no combinational logic after the flops.

Optional Feature:
- Macro: CAD_SER_PARITY_EN.
- Defined:
  - Each result is followed by one extra bit equal to the even parity (XOR) of all RESULT_W bits.
  - Frame length is RESULT_W+1 cycles.
  - out_last is on the parity bit.
- Undefined:
  - Frame length is RESULT_W cycles.
  - No parity logic is synthesised.

Decomposition:
- Shared package cad_pkg:
  - typedef cad_result_t (signed, RESULT_W default).
  - enum ser_state_e {SER_IDLE, SER_SHIFT}.
  - localparam CAD_RESULT_W = 20.
- One natural sub-module: cad_sync_fifo.
  - Parametrised width/depth.
  - Ports: push, pop, din, dout, full, empty, level; async active-low reset.
  - Instantiated with width RESULT_W+1.
- The serialiser FSM and shift logic stay in the top module.

Test Plan:
- Single LSB-first push of 20'h80001 after reset:
  - out_valid rises 2 cycles after the push edge.
  - Bit stream is 1, then eighteen 0s, then 1.
  - out_last only on cycle 20; out_valid falls afterwards.
- Single MSB-first push of -1 (20'hFFFFF), then 20'h00000 LSB-first, back-to-back:
  - 40 consecutive out_valid cycles: twenty 1s then twenty 0s.
  - out_last pulses at cycles 20 and 40.
  - No bubble between the two results.
- Fill to DEPTH=4 while the first result shifts:
  - fifo_level reaches 4 and in_ready drops to 0.
  - After the next pop, in_ready returns to 1 and fifo_level = 3.
  - All 5 results emerge in push order, unaltered.
- Assert rst_n low at bit 7 of a result with 2 entries queued:
  - out_valid, out_value and out_last go to 0 asynchronously.
  - After release, fifo_level = 0 and no further bits appear until a new push.
- Simultaneous push and last-bit pop with level 2:
  - Level stays 2.
  - The next result starts on the immediately following cycle.
- With CAD_SER_PARITY_EN, push 20'h00007:
  - 21-cycle frame whose final bit = 1 (odd count of ones → parity 1).
  - out_last is on cycle 21.
